// File: rtl/sequential_divider.sv
// Iterative restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to compile in two's-complement operands (sign fix-up in FINISH).
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | waiting for start; operands latched on accepted start
  // CALC   | one restoring iteration per clock, count 0..WIDTH-1
  // FINISH | register results (sign fix-up if enabled), pulse done
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  // Partial remainder is always < divisor after restore, so WIDTH bits hold it.
  logic [WIDTH-1:0] dq, acc, dvsr;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] acc_nxt, dq_nxt;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] dvnd_raw;

  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fix = (dvsr == '0) ? '1       : (q_neg ? -dq  : dq);
  assign r_fix = (dvsr == '0) ? dvnd_raw : (r_neg ? -acc : acc);
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = dq;
  assign r_fix = acc;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_sh  = {acc, dq[WIDTH-1]};
    dq_nxt  = {dq[WIDTH-2:0], 1'b0};
    acc_nxt = acc_sh[WIDTH-1:0];
    if (acc_sh >= {1'b0, dvsr}) begin
      acc_nxt   = acc_sh[WIDTH-1:0] - dvsr;
      dq_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq          <= '0;
      acc         <= '0;
      dvsr        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dvnd_raw    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dq    <= a_mag;
            dvsr  <= b_mag;
            acc   <= '0;
            count <= '0;
`ifdef DIV_SIGNED_EN
            q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg    <= dividend[WIDTH-1];
            dvnd_raw <= dividend;
`endif
          end
        end
        CALC: begin
          dq    <= dq_nxt;
          acc   <= acc_nxt;
          count <= count + CW'(1);
        end
        FINISH: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= (dvsr == '0);
          done        <= 1'b1;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider (WIDTH=16).
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_sequential_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Issues one start, scrambles operands after E0, waits (bounded) for done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output int busy_cnt, output bit timed_out);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({quotient, remainder, div_by_zero, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0",
               quotient, remainder, div_by_zero, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e, bc; bit to;
    do_div(16'd100, 16'd7, e, bc, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL basic_timeout: done never seen, want done"); end
    n_cmp++;
    if (e !== 17) begin n_err++; $display("FAIL basic_latency: got %0d edges after E0, want 17", e); end
    n_cmp++;
    if (bc !== 17) begin n_err++; $display("FAIL basic_busy: got %0d busy cycles, want 17", bc); end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got done=%b one cycle later, want 0", done); end
    n_cmp++;
    if (quotient !== 16'd14) begin n_err++; $display("FAIL result_hold: got q=%0d, want 14", quotient); end
  endtask

  task automatic test_vectors;
    logic [W-1:0] a_v [3] = '{16'hFFFF, 16'h0003, 16'd5};
    logic [W-1:0] b_v [3] = '{16'h0001, 16'h000A, 16'd0};
    logic [W-1:0] q_v [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [W-1:0] r_v [3] = '{16'h0000, 16'h0003, 16'd5};
    logic         z_v [3] = '{1'b0, 1'b0, 1'b1};
    int e, bc; bit to;
    for (int i = 0; i < 3; i++) begin
      do_div(a_v[i], b_v[i], e, bc, to);
      n_cmp++;
      if (to || e !== 17) begin
        n_err++;
        $display("FAIL vec%0d_latency: got %0d edges (timeout=%b), want 17", i, e, to);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {q_v[i], r_v[i], z_v[i]}) begin
        n_err++;
        $display("FAIL vec%0d_result: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, q_v[i], r_v[i], z_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int e, bc; bit to;
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({quotient, remainder, div_by_zero, busy, done} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0",
               quotient, remainder, div_by_zero, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_idle: got busy=%b done=%b after release, want 0 0", busy, done);
    end
    do_div(16'd1000, 16'd3, e, bc, to);
    n_cmp++;
    if (to || {quotient, remainder, div_by_zero} !== {16'd333, 16'd1, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_rerun: got q=%0d r=%0d dbz=%b timeout=%b, want q=333 r=1 dbz=0",
               quotient, remainder, div_by_zero, to);
    end
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int first_at = -1;
    int second_at = -1;
    @(negedge clk);
    dividend = 16'd200;
    divisor  = 16'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    while (second_at < 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done && first_at < 0) begin
        first_at = cyc;
        n_cmp++;
        if ({quotient, remainder} !== {16'd50, 16'd0}) begin
          n_err++;
          $display("FAIL b2b_first: got q=%0d r=%0d, want q=50 r=0", quotient, remainder);
        end
        dividend = 16'd7;
        divisor  = 16'd2;
      end else if (done) begin
        second_at = cyc;
        start = 1'b0;
        n_cmp++;
        if ({quotient, remainder} !== {16'd3, 16'd1}) begin
          n_err++;
          $display("FAIL b2b_second: got q=%0d r=%0d, want q=3 r=1", quotient, remainder);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (first_at !== 17 || second_at - first_at !== 18) begin
      n_err++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d, want first=17 spacing=18",
               first_at, second_at);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: got busy=%b after start dropped, want 0", busy); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    logic [W-1:0] a_v [3] = '{16'hFFF9, 16'h8000, 16'hFFF9};
    logic [W-1:0] b_v [3] = '{16'h0002, 16'hFFFF, 16'h0000};
    logic [W-1:0] q_v [3] = '{16'hFFFD, 16'h8000, 16'hFFFF};
    logic [W-1:0] r_v [3] = '{16'hFFFF, 16'h0000, 16'hFFF9};
    logic         z_v [3] = '{1'b0, 1'b0, 1'b1};
    int e, bc; bit to;
    for (int i = 0; i < 3; i++) begin
      do_div(a_v[i], b_v[i], e, bc, to);
      n_cmp++;
      if (to || {quotient, remainder, div_by_zero} !== {q_v[i], r_v[i], z_v[i]}) begin
        n_err++;
        $display("FAIL signed%0d: got q=%h r=%h dbz=%b timeout=%b, want q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, to, q_v[i], r_v[i], z_v[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_reset_mid;
    test_back_to_back;
`ifdef DIV_SIGNED_EN
    test_signed;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
